// File: rtl/sensor_conditioner.sv
// -----------------------------------------------------------------------------
// sensor_conditioner
//
// Input-conditioning stage in front of the home-automation controller. The
// raw, asynchronous door/window/fire sensor levels are synchronised and
// debounced. The raw temperature bus is synchronised and stability-filtered.
// The controller sees clean levels, a temperature-valid flag and a one-cycle
// change strobe.
//
// Parameters
//   DB_CNT : consecutive stable cycles needed before a new level is accepted
//            (2..255)
//   ST_W   : temperature bus width
//
// Ports
//   Clk        in   system clock, rising edge
//   Rst_n      in   asynchronous active-low reset
//   SFD        in   raw front-door sensor
//   SRD        in   raw rear-door sensor
//   SW         in   raw window sensor
//   SFA        in   raw fire-alarm sensor
//   ST         in   raw temperature, unsigned, ST_W bits
//   SFD_o      out  debounced front door
//   SRD_o      out  debounced rear door
//   SW_o       out  debounced window
//   SFA_o      out  debounced fire alarm
//   ST_o       out  accepted temperature
//   temp_valid out  ST_o holds at least one accepted sample
//   chg        out  one-cycle strobe: some conditioned output changed
//
// Build option
//   SENSOR_COND_FIRE_FAST_EN : when defined, a rising fire-alarm level skips
//   the debounce and reaches SFA_o one edge after the second synchroniser
//   stage reads 1. The falling edge stays fully debounced.
// -----------------------------------------------------------------------------
module sensor_conditioner #(
    parameter int DB_CNT = 4,
    parameter int ST_W   = 7
) (
    input  logic            Clk,
    input  logic            Rst_n,
    input  logic            SFD,
    input  logic            SRD,
    input  logic            SW,
    input  logic            SFA,
    input  logic [ST_W-1:0] ST,
    output logic            SFD_o,
    output logic            SRD_o,
    output logic            SW_o,
    output logic            SFA_o,
    output logic [ST_W-1:0] ST_o,
    output logic            temp_valid,
    output logic            chg
);

    localparam int            CW       = $clog2(DB_CNT);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CNT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    // Binary channels, bit order: 0=front door, 1=rear door, 2=window, 3=fire.
    logic [3:0]         bin_raw;
    logic [3:0]         bin_s1_q, bin_s1_d;
    logic [3:0]         bin_s2_q, bin_s2_d;
    logic [3:0]         bin_d_q,  bin_d_d;
    logic [3:0][CW-1:0] bin_c_q,  bin_c_d;

    // Temperature path.
    logic [ST_W-1:0]    ts1_q, ts1_d;
    logic               ts1_vld_q, ts1_vld_d;
    logic [ST_W-1:0]    cand_q, cand_d;
    logic               cand_vld_q, cand_vld_d;
    logic [CW-1:0]      tc_q, tc_d;
    logic [ST_W-1:0]    st_o_q, st_o_d;
    logic               temp_valid_q, temp_valid_d;
    logic               need_upd;

    logic               chg_q, chg_d;

    assign bin_raw = {SFA, SW, SRD, SFD};

    // -------------------------------------------------------------------------
    // Binary synchronise + debounce
    // -------------------------------------------------------------------------
    always_comb begin
        bin_s1_d = bin_raw;
        bin_s2_d = bin_s1_q;
        bin_d_d  = bin_d_q;
        bin_c_d  = bin_c_q;
        for (int i = 0; i < 4; i++) begin
            if (bin_s2_q[i] == bin_d_q[i]) begin
                // Back at the accepted level: any count in progress restarts.
                bin_c_d[i] = '0;
            end else if (bin_c_q[i] == CNT_LAST) begin
                bin_d_d[i] = bin_s2_q[i];
                bin_c_d[i] = '0;
            end else begin
                bin_c_d[i] = bin_c_q[i] + CNT_ONE;
            end
        end
`ifdef SENSOR_COND_FIRE_FAST_EN
        // A fire alarm is safety-critical: take the rising level at once.
        if (bin_s2_q[3] && !bin_d_q[3]) begin
            bin_d_d[3] = 1'b1;
            bin_c_d[3] = '0;
        end
`else
`endif
    end

    // -------------------------------------------------------------------------
    // Temperature synchronise + stability filter
    //
    // cand_q is loaded from the first synchroniser stage on every mismatch and
    // otherwise already equals it, so it also serves as the second
    // synchroniser stage. This gives the temperature path the same latency as
    // the binary path. The valid flags keep the reset contents of the
    // synchroniser from counting as a sample. Without them, ST=0 held
    // from reset would be accepted two edges early.
    // -------------------------------------------------------------------------
    always_comb begin
        ts1_d        = ST;
        ts1_vld_d    = 1'b1;
        cand_d       = cand_q;
        cand_vld_d   = cand_vld_q;
        tc_d         = tc_q;
        st_o_d       = st_o_q;
        temp_valid_d = temp_valid_q;
        need_upd     = (cand_q != st_o_q) || !temp_valid_q;

        if (!ts1_vld_q) begin
            tc_d = '0;
        end else if (!cand_vld_q || (ts1_q != cand_q)) begin
            cand_d     = ts1_q;
            cand_vld_d = 1'b1;
            tc_d       = '0;
        end else if (need_upd && (tc_q == CNT_LAST)) begin
            st_o_d       = cand_q;
            temp_valid_d = 1'b1;
            tc_d         = '0;
        end else if (need_upd) begin
            tc_d = tc_q + CNT_ONE;
        end else begin
            tc_d = '0;
        end
    end

    // -------------------------------------------------------------------------
    // Change strobe: registered so it coincides with the updated outputs.
    // -------------------------------------------------------------------------
    always_comb begin
        chg_d = (bin_d_d != bin_d_q)
             || (st_o_d != st_o_q)
             || (temp_valid_d && !temp_valid_q);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            bin_s1_q     <= '0;
            bin_s2_q     <= '0;
            bin_d_q      <= '0;
            bin_c_q      <= '0;
            ts1_q        <= '0;
            ts1_vld_q    <= 1'b0;
            cand_q       <= '0;
            cand_vld_q   <= 1'b0;
            tc_q         <= '0;
            st_o_q       <= '0;
            temp_valid_q <= 1'b0;
            chg_q        <= 1'b0;
        end else begin
            bin_s1_q     <= bin_s1_d;
            bin_s2_q     <= bin_s2_d;
            bin_d_q      <= bin_d_d;
            bin_c_q      <= bin_c_d;
            ts1_q        <= ts1_d;
            ts1_vld_q    <= ts1_vld_d;
            cand_q       <= cand_d;
            cand_vld_q   <= cand_vld_d;
            tc_q         <= tc_d;
            st_o_q       <= st_o_d;
            temp_valid_q <= temp_valid_d;
            chg_q        <= chg_d;
        end
    end

    assign SFD_o      = bin_d_q[0];
    assign SRD_o      = bin_d_q[1];
    assign SW_o       = bin_d_q[2];
    assign SFA_o      = bin_d_q[3];
    assign ST_o       = st_o_q;
    assign temp_valid = temp_valid_q;
    assign chg        = chg_q;

endmodule

// File: tb/tb_sensor_conditioner.sv
// -----------------------------------------------------------------------------
// tb_sensor_conditioner
//
// Directed bench for sensor_conditioner with DB_CNT=4 and ST_W=7. A table of
// {inputs, cycle count, expected outputs} rows drives the main behaviours.
// Hand-written sequences then cover asynchronous reset in mid-count and the
// fire-alarm path. The bench adapts the expected fire-alarm latency when
// SENSOR_COND_FIRE_FAST_EN is defined.
// -----------------------------------------------------------------------------
module tb_sensor_conditioner;

    localparam int DB_CNT = 4;
    localparam int ST_W   = 7;

`ifdef SENSOR_COND_FIRE_FAST_EN
    localparam int FIRE_RISE = 3;
`else
    localparam int FIRE_RISE = 6;
`endif

    logic            Clk;
    logic            Rst_n;
    logic            SFD, SRD, SW, SFA;
    logic [ST_W-1:0] ST;
    logic            SFD_o, SRD_o, SW_o, SFA_o;
    logic [ST_W-1:0] ST_o;
    logic            temp_valid;
    logic            chg;

    int total;
    int bad;

    sensor_conditioner #(
        .DB_CNT(DB_CNT),
        .ST_W  (ST_W)
    ) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .SFD       (SFD),
        .SRD       (SRD),
        .SW        (SW),
        .SFA       (SFA),
        .ST        (ST),
        .SFD_o     (SFD_o),
        .SRD_o     (SRD_o),
        .SW_o      (SW_o),
        .SFA_o     (SFA_o),
        .ST_o      (ST_o),
        .temp_valid(temp_valid),
        .chg       (chg)
    );

    // ---------------------------------------------------------------- clock
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // ------------------------------------------------------------- vectors
    // Expected outputs are packed as {SFD_o,SRD_o,SW_o,SFA_o,ST_o,temp_valid,chg}.
    typedef struct {
        logic            sfd;
        logic            srd;
        logic            sw;
        logic            sfa;
        logic [ST_W-1:0] st;
        int              cycles;
        logic [12:0]     exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [12:0] mk_exp(input logic a, input logic b,
                                           input logic c, input logic d,
                                           input logic [ST_W-1:0] st,
                                           input logic tv, input logic ch);
        return {a, b, c, d, st, tv, ch};
    endfunction

    task automatic add_vec(input logic sfd, input logic srd, input logic sw,
                           input logic sfa, input logic [ST_W-1:0] st,
                           input int cycles,
                           input logic e_sfd, input logic e_srd,
                           input logic e_sw, input logic e_sfa,
                           input logic [ST_W-1:0] e_st,
                           input logic e_tv, input logic e_chg);
        vec_t v;
        v.sfd    = sfd;
        v.srd    = srd;
        v.sw     = sw;
        v.sfa    = sfa;
        v.st     = st;
        v.cycles = cycles;
        v.exp    = mk_exp(e_sfd, e_srd, e_sw, e_sfa, e_st, e_tv, e_chg);
        vecs.push_back(v);
    endtask

    // ---------------------------------------------------------- scoreboard
    task automatic check(input string name, input logic [12:0] exp);
        logic [12:0] act;
        act = {SFD_o, SRD_o, SW_o, SFA_o, ST_o, temp_valid, chg};
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got={sfd%b srd%b sw%b sfa%b st%h tv%b chg%b} want={sfd%b srd%b sw%b sfa%b st%h tv%b chg%b}",
                     name, act[12], act[11], act[10], act[9], act[8:2], act[1], act[0],
                     exp[12], exp[11], exp[10], exp[9], exp[8:2], exp[1], exp[0]);
        end
    endtask

    // Advance one rising edge and sample the outputs 1 ns later.
    task automatic step_check(input string name, input logic [12:0] exp);
        @(posedge Clk);
        #1;
        check(name, exp);
    endtask

    // ------------------------------------------------------------ stimulus
    initial begin
        total = 0;
        bad   = 0;
        Rst_n = 1'b0;
        SFD   = 1'b0;
        SRD   = 1'b0;
        SW    = 1'b0;
        SFA   = 1'b0;
        ST    = '0;

        // Table rows, applied from the first edge after reset release.
        // Initial zero acceptance: ST=0 from reset, accepted on the 6th edge.
        add_vec(0,0,0,0,7'h00, 5, 0,0,0,0,7'h00,0,0);
        add_vec(0,0,0,0,7'h00, 1, 0,0,0,0,7'h00,1,1);
        add_vec(0,0,0,0,7'h00, 4, 0,0,0,0,7'h00,1,0);
        // Window glitch of 3 cycles is rejected.
        add_vec(0,0,1,0,7'h00, 3, 0,0,0,0,7'h00,1,0);
        add_vec(0,0,0,0,7'h00, 8, 0,0,0,0,7'h00,1,0);
        // Window pulse of 4 cycles: SW_o high for 4 cycles, two chg pulses.
        add_vec(0,0,1,0,7'h00, 4, 0,0,0,0,7'h00,1,0);
        add_vec(0,0,0,0,7'h00, 1, 0,0,0,0,7'h00,1,0);
        add_vec(0,0,0,0,7'h00, 1, 0,0,1,0,7'h00,1,1);
        add_vec(0,0,0,0,7'h00, 3, 0,0,1,0,7'h00,1,0);
        add_vec(0,0,0,0,7'h00, 1, 0,0,0,0,7'h00,1,1);
        add_vec(0,0,0,0,7'h00, 3, 0,0,0,0,7'h00,1,0);
        // Front and rear doors rise together, then rear falls alone.
        add_vec(1,1,0,0,7'h00, 5, 0,0,0,0,7'h00,1,0);
        add_vec(1,1,0,0,7'h00, 1, 1,1,0,0,7'h00,1,1);
        add_vec(1,1,0,0,7'h00, 3, 1,1,0,0,7'h00,1,0);
        add_vec(1,0,0,0,7'h00, 5, 1,1,0,0,7'h00,1,0);
        add_vec(1,0,0,0,7'h00, 1, 1,0,0,0,7'h00,1,1);
        add_vec(1,0,0,0,7'h00, 2, 1,0,0,0,7'h00,1,0);
        // Temperature toggling every 2 cycles is never accepted, then settles.
        add_vec(1,0,0,0,7'h19, 2, 1,0,0,0,7'h00,1,0);
        add_vec(1,0,0,0,7'h1A, 2, 1,0,0,0,7'h00,1,0);
        add_vec(1,0,0,0,7'h19, 2, 1,0,0,0,7'h00,1,0);
        add_vec(1,0,0,0,7'h1A, 2, 1,0,0,0,7'h00,1,0);
        add_vec(1,0,0,0,7'h19, 2, 1,0,0,0,7'h00,1,0);
        add_vec(1,0,0,0,7'h1A, 5, 1,0,0,0,7'h00,1,0);
        add_vec(1,0,0,0,7'h1A, 1, 1,0,0,0,7'h1A,1,1);
        add_vec(1,0,0,0,7'h1A, 3, 1,0,0,0,7'h1A,1,0);

        // Reset values while reset is held.
        repeat (3) @(posedge Clk);
        #1;
        check("reset_state", mk_exp(0,0,0,0,7'h00,0,0));
        Rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            SFD = vecs[i].sfd;
            SRD = vecs[i].srd;
            SW  = vecs[i].sw;
            SFA = vecs[i].sfa;
            ST  = vecs[i].st;
            for (int c = 0; c < vecs[i].cycles; c++)
                step_check($sformatf("vec%0d.%0d", i, c), vecs[i].exp);
        end

        // Front door falls: debounced, drops on the 6th edge.
        SFD = 1'b0;
        for (int s = 1; s <= 6; s++)
            step_check($sformatf("sfd_fall.%0d", s),
                       mk_exp((s < 6), 0,0,0, 7'h1A, 1, (s == 6)));

        // Front door rises and is mid-count when reset hits.
        SFD = 1'b1;
        for (int s = 1; s <= 3; s++)
            step_check($sformatf("sfd_precount.%0d", s), mk_exp(0,0,0,0,7'h1A,1,0));
        Rst_n = 1'b0;
        #1;
        check("async_reset", mk_exp(0,0,0,0,7'h00,0,0));
        for (int s = 1; s <= 2; s++)
            step_check($sformatf("reset_hold.%0d", s), mk_exp(0,0,0,0,7'h00,0,0));
        Rst_n = 1'b1;
        // SFD and ST held: both land on the 6th edge after release, one chg.
        for (int s = 1; s <= 7; s++) begin
            if (s < 6)
                step_check($sformatf("release.%0d", s), mk_exp(0,0,0,0,7'h00,0,0));
            else
                step_check($sformatf("release.%0d", s), mk_exp(1,0,0,0,7'h1A,1,(s == 6)));
        end

        // Fire alarm rise (fast or debounced) and debounced fall.
        SFA = 1'b1;
        for (int s = 1; s <= 8; s++)
            step_check($sformatf("sfa_rise.%0d", s),
                       mk_exp(1,0,0,(s >= FIRE_RISE),7'h1A,1,(s == FIRE_RISE)));
        SFA = 1'b0;
        for (int s = 1; s <= 8; s++)
            step_check($sformatf("sfa_fall.%0d", s),
                       mk_exp(1,0,0,(s < 6),7'h1A,1,(s == 6)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sensor_conditioner.md
Name: sensor_conditioner

Overview:
- Input-conditioning stage directly upstream of the home-automation controller.
- Takes the raw asynchronous door, window and fire sensor levels (SFD, SRD, SW, SFA) and the raw temperature bus ST from the board pins.
- Synchronises and debounces each binary sensor, and stability-filters the temperature bus.
- Presents clean, glitch-free levels plus a temperature-valid flag and a change strobe to the controller.

Parameters:
- DB_CNT, 4: consecutive stable cycles required before a new level is accepted; legal range 2..255; internal counters are $clog2(DB_CNT) bits.
- ST_W, 7: temperature bus width.

Ports:
- Clk  input  1  system clock; all logic on the rising edge.
- Rst_n  input  1  asynchronous active-low reset.
- SFD  input  1  raw front-door sensor.
- SRD  input  1  raw rear-door sensor.
- SW  input  1  raw window sensor.
- SFA  input  1  raw fire-alarm sensor.
- ST  input  ST_W  raw temperature, unsigned.
- SFD_o  output  1  debounced front door.
- SRD_o  output  1  debounced rear door.
- SW_o  output  1  debounced window.
- SFA_o  output  1  debounced fire alarm.
- ST_o  output  ST_W  accepted temperature.
- temp_valid  output  1  ST_o holds at least one accepted sample.
- chg  output  1  one-cycle strobe: some conditioned output changed this cycle.

Behaviour:
- Reset (Rst_n=0, asynchronous, any time incl. mid-count): clears all sync flops, candidates, counters and outputs. SFD_o=SRD_o=SW_o=SFA_o=0, ST_o=0, temp_valid=0, chg=0.
- Release is synchronous to Clk; the first counting edge is the one after the release.
- Sync: each input passes two flops (s1→s2). ST is synchronised bitwise; the stability filter below removes multi-bit skew.
- Binary debounce, per bit, with debounced output d and counter c:
  - s2==d: c<=0.
  - s2!=d and c==DB_CNT-1: d<=s2, c<=0.
  - Otherwise: c<=c+1.
  - Any return of s2 to d before acceptance restarts the count.
- Latency: a level stable from rising edge k onward appears on the output after edge k+DB_CNT+1, i.e. on the (DB_CNT+2)th edge counting k. With DB_CNT=4 that is 6 edges.
- Pulses shorter than DB_CNT cycles after sync never reach the outputs.
- Temperature filter, with candidate register cand and counter tc:
  - ts!=cand: cand<=ts, tc<=0.
  - ts==cand, (cand!=ST_o or temp_valid==0) and tc==DB_CNT-1: ST_o<=cand, temp_valid<=1, tc<=0.
  - ts==cand, (cand!=ST_o or temp_valid==0) and tc<DB_CNT-1: tc<=tc+1.
  - Otherwise: tc<=0.
  - Latency is identical to the binary path.
  - temp_valid stays 1 until reset.
  - The first acceptance after reset sets temp_valid even when the value equals the reset ST_o (0).
- chg:
  - Registered and asserted in the same cycle the updated output value first appears.
  - Set when any of SFD_o, SRD_o, SW_o, SFA_o or ST_o changes value, or temp_valid rises.
  - Simultaneous changes still give one single-cycle pulse.
  - Back-to-back acceptances give chg high on consecutive cycles.
- Channels are fully independent. Simultaneous transitions on several sensors each complete on their own schedule.

Optional Feature:
- Macro: SENSOR_COND_FIRE_FAST_EN.
- Defined: SFA_o rising edge bypasses debounce. SFA_o<=1 on the edge after s2 first reads 1 (latency 3 edges from sample). chg fires with it. SFA_o falling edge stays fully debounced (DB_CNT rule).
- Undefined: SFA is debounced symmetrically like the other sensors.

Test Plan (DB_CNT=4, ST_W=7):
- Reset behaviour: assert Rst_n=0 mid-count with SFD=1 for 3 cycles → all outputs 0 immediately. Release with SFD held 1 → SFD_o=1 on the 6th edge after release, chg=1 for exactly that cycle.
- Glitch rejection: SW pulses high for 3 cycles then returns 0 → SW_o stays 0, chg never asserts. A 4-cycle pulse → SW_o=1 for 4 cycles, chg pulses twice.
- Temperature settle: ST toggles 0x19/0x1A every 2 cycles for 10 cycles, then holds 0x1A → ST_o=0x1A and temp_valid=1 on the 6th edge after the hold starts. No earlier update occurs.
- Initial zero acceptance: ST=0 from reset → temp_valid=1 after 6 edges, ST_o=0, one chg pulse. Subsequent steady ST gives no further chg.
- Simultaneous changes: SFD and SRD rise on the same edge → both outputs update the same cycle, chg high for one cycle only. SRD then falls while SFD is held → only SRD_o changes.
- Fire fast path: SFA rises, with and without SENSOR_COND_FIRE_FAST_EN → SFA_o=1 after 3 edges (defined) vs 6 edges (undefined). SFA falls → SFA_o=0 after 6 edges in both builds.
